// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle logic ops, iterative shift-add MUL and restoring DIV.
// Optional ALU_FLAGS_EN adds registered zf/nf/vf outputs.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         opcode,
  input  logic               en,
  output logic               busy,
  output logic               ack,
  output logic [2*WIDTH-1:0] result,
`ifdef ALU_FLAGS_EN
  output logic               zf,
  output logic               nf,
  output logic               vf,
`endif
  output logic               dz
);

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [W2-1:0]     p, p_nxt;
  logic [WIDTH-1:0]  opnd, opnd_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, ack_nxt, dz_nxt;
  logic [W2-1:0]     res_nxt;

  logic [WIDTH:0]    add_s, sub_s;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_p;
  logic [WIDTH:0]    div_r, div_d;
  logic              div_ge;
  logic [W2-1:0]     div_p;

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};

  // p holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum = {1'b0, p[W2-1:WIDTH]}
                 + (p[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_p   = {mul_sum, p[WIDTH-1:1]};

  assign div_r  = p[W2-1:WIDTH-1];
  assign div_d  = div_r - {1'b0, opnd};
  assign div_ge = ~div_d[WIDTH];
  assign div_p  = {div_ge ? div_d[WIDTH-1:0] : div_r[WIDTH-1:0],
                   p[WIDTH-2:0], div_ge};

  always_comb begin
    state_nxt = state;
    p_nxt     = p;
    opnd_nxt  = opnd;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ack_nxt   = 1'b0;
    res_nxt   = result;
    dz_nxt    = dz;
    unique case (state)
      IDLE: begin
        if (en) begin
          unique case (opcode)
            3'b000: begin
              res_nxt = {{(WIDTH-1){1'b0}}, add_s};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b001: begin
              res_nxt = {{(WIDTH-1){1'b0}}, sub_s};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b010: begin
              res_nxt = {{WIDTH{1'b0}}, a & b};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b011: begin
              res_nxt = {{WIDTH{1'b0}}, a | b};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b100: begin
              res_nxt = {{WIDTH{1'b0}}, a ^ b};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b101: begin
              res_nxt = {{(W2-1){1'b0}},
                         $signed(a) < $signed(b)};
              ack_nxt = 1'b1;
              dz_nxt  = 1'b0;
            end
            3'b110: begin
              state_nxt = MUL;
              busy_nxt  = 1'b1;
              cnt_nxt   = CNT_W'(WIDTH);
              opnd_nxt  = a;
              p_nxt     = {{WIDTH{1'b0}}, b};
            end
            3'b111: begin
              if (b == '0) begin
                res_nxt = {a, {WIDTH{1'b1}}};
                ack_nxt = 1'b1;
                dz_nxt  = 1'b1;
              end else begin
                state_nxt = DIV;
                busy_nxt  = 1'b1;
                cnt_nxt   = CNT_W'(WIDTH);
                opnd_nxt  = b;
                p_nxt     = {{WIDTH{1'b0}}, a};
              end
            end
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_nxt = cnt - 1'b1;
        p_nxt   = (state == MUL) ? mul_p : div_p;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          ack_nxt   = 1'b1;
          res_nxt   = p_nxt;
          dz_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= '0;
      opnd   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      ack    <= 1'b0;
      result <= '0;
      dz     <= 1'b0;
    end else begin
      state  <= state_nxt;
      p      <= p_nxt;
      opnd   <= opnd_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      ack    <= ack_nxt;
      result <= res_nxt;
      dz     <= dz_nxt;
    end
  end

`ifdef ALU_FLAGS_EN
  logic v_add, v_sub;

  assign v_add = (a[WIDTH-1] == b[WIDTH-1])
              && (add_s[WIDTH-1] != a[WIDTH-1]);
  assign v_sub = (a[WIDTH-1] != b[WIDTH-1])
              && (sub_s[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      nf <= 1'b0;
      vf <= 1'b0;
    end else if (ack_nxt) begin
      zf <= (res_nxt[WIDTH-1:0] == '0);
      nf <= res_nxt[WIDTH-1];
      if (state == IDLE && opcode == 3'b000)
        vf <= v_add;
      else if (state == IDLE && opcode == 3'b001)
        vf <= v_sub;
      else
        vf <= 1'b0;
    end
  end
`endif

endmodule
